// File: rtl/dual_edge_regen_if.sv
// dual_edge_regen_if: strobe inputs, clear, and regenerated-level status
// outputs of dual_edge_regen, bundled as one port.
// The master drives the strobes and clear. The slave (the regenerator)
// drives the level and the status.
interface dual_edge_regen_if #(
  parameter int PEND_DEPTH = 3
) ();
  localparam int PW = $clog2(PEND_DEPTH + 1);

  logic          rise;
  logic          fall;
  logic          clr;
  logic          out;
  logic          busy;
  logic [PW-1:0] pending;
  logic          ovf;
  logic          err;

  modport master (
    output rise, fall, clr,
    input  out, busy, pending, ovf, err
  );

  modport slave (
    input  rise, fall, clr,
    output out, busy, pending, ovf, err
  );
endinterface

// File: rtl/dual_edge_regen.sv
// dual_edge_regen: rebuilds a level from one-cycle rise/fall strobes.
// Each accepted strobe toggles out. A new level is held for MIN_HOLD
// cycles. Strobes that arrive during a hold are queued, up to PEND_DEPTH
// of them, and are replayed one per MIN_HOLD cycles.
// Optional feature macro: DUAL_REGEN_DIR_CHECK_EN. When it is defined,
// strobes that would not change the final level are rejected and flagged
// on err. When it is undefined, err is tied low.
module dual_edge_regen #(
  parameter int MIN_HOLD   = 4,
  parameter int PEND_DEPTH = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  dual_edge_regen_if.slave bus
);
  localparam int PW = $clog2(PEND_DEPTH + 1);
  localparam int HW = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(MIN_HOLD - 1);
  localparam logic [PW-1:0] PEND_MAX  = PW'(PEND_DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // An odd number of queued toggles inverts the level that will finally
  // settle relative to the current out.
  function automatic logic queue_odd(input logic [PW-1:0] cnt);
    return cnt[0];
  endfunction

  state_t        state_q,    state_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [PW-1:0] pending_q,  pending_d;
  logic          out_q,      out_d;
  logic          busy_q,     busy_d;
  logic          ovf_q,      ovf_d;
  logic          err_q,      err_d;

  logic          acc_s;
  logic          err_evt_s;
  logic          ovf_evt_s;
  logic [PW:0]   p_s;

`ifdef DUAL_REGEN_DIR_CHECK_EN
  logic          both_s;
  logic          exp_lvl_s;
  logic          dir_bad_s;

  // Qualify strobes: drop simultaneous strobes and wrong-direction strobes.
  always_comb begin
    both_s    = bus.rise & bus.fall;
    exp_lvl_s = out_q ^ queue_odd(pending_q);
    dir_bad_s = (bus.rise & ~bus.fall & exp_lvl_s) |
                (bus.fall & ~bus.rise & ~exp_lvl_s);
    acc_s     = (bus.rise ^ bus.fall) & ~dir_bad_s;
    err_evt_s = both_s | dir_bad_s;
  end
`else
  // Qualify strobes: only a lone rise or a lone fall is a toggle request.
  always_comb begin
    acc_s     = bus.rise ^ bus.fall;
    err_evt_s = 1'b0;
  end
`endif

  // Next-state logic for the hold/queue machine and the sticky flags.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    pending_d  = pending_q;
    out_d      = out_q;
    ovf_evt_s  = 1'b0;
    p_s        = {1'b0, pending_q} + {{PW{1'b0}}, acc_s};
    case (state_q)
      ST_IDLE: begin
        if (acc_s) begin
          out_d      = ~out_q;
          hold_cnt_d = HOLD_LOAD;
          state_d    = ST_HOLD;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (hold_cnt_q != {HW{1'b0}}) begin
          hold_cnt_d = hold_cnt_q - HW'(1);
          if (acc_s && (pending_q == PEND_MAX)) begin
            ovf_evt_s = 1'b1;
          end else if (acc_s) begin
            pending_d = pending_q + PW'(1);
          end else begin
            pending_d = pending_q;
          end
        end else if (p_s != {(PW+1){1'b0}}) begin
          // The expiry cycle dequeues one toggle while a same-cycle strobe
          // enqueues, so the queue cannot overflow here.
          out_d      = ~out_q;
          pending_d  = p_s[PW-1:0] - PW'(1);
          hold_cnt_d = HOLD_LOAD;
          state_d    = ST_HOLD;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        hold_cnt_d = {HW{1'b0}};
        pending_d  = {PW{1'b0}};
      end
    endcase
    busy_d = (state_d == ST_HOLD);
    // A new event in the same cycle as clr keeps the flag set.
    ovf_d  = ovf_evt_s | (ovf_q & ~bus.clr);
`ifdef DUAL_REGEN_DIR_CHECK_EN
    err_d  = err_evt_s | (err_q & ~bus.clr);
`else
    err_d  = err_evt_s;
`endif
  end

  // State and output registers. Reset discards the queue and the hold at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      hold_cnt_q <= {HW{1'b0}};
      pending_q  <= {PW{1'b0}};
      out_q      <= 1'b0;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      pending_q  <= pending_d;
      out_q      <= out_d;
      busy_q     <= busy_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
    end
  end

  assign bus.out     = out_q;
  assign bus.busy    = busy_q;
  assign bus.pending = pending_q;
  assign bus.ovf     = ovf_q;
  assign bus.err     = err_q;
endmodule

// File: tb/tb_dual_edge_regen.sv
// tb_dual_edge_regen: scoreboard bench for dual_edge_regen.
// The reference model keeps a schedule of absolute toggle times. An
// accepted strobe at edge t toggles out at max(t, last toggle + MIN_HOLD).
// The outputs after each edge are read off that schedule.
module tb_dual_edge_regen;
  localparam int MIN_HOLD   = 4;
  localparam int PEND_DEPTH = 3;
  localparam int PW         = $clog2(PEND_DEPTH + 1);

  typedef struct packed {
    logic          out;
    logic          busy;
    logic [PW-1:0] pending;
    logic          ovf;
    logic          err;
  } exp_t;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;
  bit   mon_en;

  exp_t exp_q[$];

  // Model state
  int   sched[$];   // toggle times not yet executed
  int   last_t;     // latest scheduled toggle time
  int   last_exec;  // latest executed toggle time
  int   t;          // index of the next active edge
  logic m_lvl;
  logic m_final;
  logic m_ovf;
  logic m_err;

  dual_edge_regen_if #(.PEND_DEPTH(PEND_DEPTH)) bus_if ();

  dual_edge_regen #(
    .MIN_HOLD  (MIN_HOLD),
    .PEND_DEPTH(PEND_DEPTH)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    sched.delete();
    last_t    = -1000;
    last_exec = -1000;
    m_lvl     = 1'b0;
    m_final   = 1'b0;
    m_ovf     = 1'b0;
    m_err     = 1'b0;
  endtask

  // Called at a negedge: drive one cycle of stimulus, push the expected
  // result for the next edge, then advance to the following negedge.
  task automatic step(input logic r, input logic f, input logic c);
    exp_t e;
    int   n_gt;
    bit   in_hold;
    bit   acc;
    bit   ovf_evt;
    bit   err_evt;
    int   when;
    bus_if.rise = r;
    bus_if.fall = f;
    bus_if.clr  = c;
    n_gt = 0;
    foreach (sched[i]) if (sched[i] > t) n_gt++;
    in_hold = (t < last_t + MIN_HOLD);
    acc     = (r != f);
    ovf_evt = 1'b0;
    err_evt = 1'b0;
`ifdef DUAL_REGEN_DIR_CHECK_EN
    if (r && f) err_evt = 1'b1;
    if (acc && ((r && m_final) || (f && !m_final))) begin
      acc     = 1'b0;
      err_evt = 1'b1;
    end
`endif
    if (acc && in_hold && (n_gt == PEND_DEPTH)) begin
      acc     = 1'b0;
      ovf_evt = 1'b1;
    end
    if (acc) begin
      when = in_hold ? (last_t + MIN_HOLD) : t;
      sched.push_back(when);
      last_t  = when;
      m_final = ~m_final;
    end
    while (sched.size() > 0 && sched[0] <= t) begin
      void'(sched.pop_front());
      m_lvl     = ~m_lvl;
      last_exec = t;
    end
    m_ovf = ovf_evt | (m_ovf & ~c);
`ifdef DUAL_REGEN_DIR_CHECK_EN
    m_err = err_evt | (m_err & ~c);
`else
    m_err = 1'b0;
`endif
    e.out     = m_lvl;
    e.busy    = (t < last_exec + MIN_HOLD);
    e.pending = PW'(sched.size());
    e.ovf     = m_ovf;
    e.err     = m_err;
    exp_q.push_back(e);
    t++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compare DUT outputs against the scoreboard after every edge.
  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        a = '{bus_if.out, bus_if.busy, bus_if.pending, bus_if.ovf, bus_if.err};
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard_empty at %0t: got out=%0b busy=%0b pending=%0d ovf=%0b err=%0b, required an expected entry",
                   $time, a.out, a.busy, a.pending, a.ovf, a.err);
        end else begin
          e = exp_q.pop_front();
          if (a !== e) begin
            n_fail++;
            $display("FAIL outputs at %0t: got out=%0b busy=%0b pending=%0d ovf=%0b err=%0b, required out=%0b busy=%0b pending=%0d ovf=%0b err=%0b",
                     $time, a.out, a.busy, a.pending, a.ovf, a.err,
                     e.out, e.busy, e.pending, e.ovf, e.err);
          end
        end
      end
    end
  end

  task automatic check_now(input string name, input logic [PW+3:0] got,
                           input logic [PW+3:0] req);
    n_checks++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  // Watchdog against a hung run.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Stimulus sequence.
  initial begin
    int x;
    logic r;
    logic f;
    logic c;
    n_checks    = 0;
    n_fail      = 0;
    mon_en      = 1'b0;
    t           = 0;
    bus_if.rise = 1'b0;
    bus_if.fall = 1'b0;
    bus_if.clr  = 1'b0;
    reset_n     = 1'b1;
    model_reset();
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_now("reset_values",
              {bus_if.out, bus_if.busy, bus_if.pending, bus_if.ovf, bus_if.err},
              {(PW+4){1'b0}});
    @(negedge clk);
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // Basic toggle
    step(1'b1, 1'b0, 1'b0);
    idle(8);
    // Queueing: rise, fall, rise back to back
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    idle(16);
    // Overflow: one toggle then four strobes during the hold, then clr
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    idle(18);
    step(1'b0, 1'b0, 1'b1);
    idle(2);
    // Expiry collision: second strobe lands exactly on the expiry edge
    step(1'b0, 1'b1, 1'b0);
    idle(3);
    step(1'b1, 1'b0, 1'b0);
    idle(8);
    // Same-direction strobe while idle, and simultaneous rise+fall
    step(1'b1, 1'b0, 1'b0);
    idle(6);
    step(1'b1, 1'b1, 1'b0);
    idle(6);

    // Randomized traffic, sparse then dense
    for (int i = 0; i < 1500; i++) begin
      x = int'($urandom_range(0, 99));
      if (i < 700) begin
        r = (x < 12);
        f = (x >= 12 && x < 24);
      end else begin
        r = (x < 30);
        f = (x >= 30 && x < 60);
      end
      if (x >= 95) begin
        r = 1'b1;
        f = 1'b1;
      end
      c = ($urandom_range(0, 15) == 0);
      step(r, f, c);
    end
    idle(20);

    // Asynchronous reset mid-hold with two queued strobes
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    mon_en = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check_now("async_reset_outputs",
              {bus_if.out, bus_if.busy, bus_if.pending, bus_if.ovf, bus_if.err},
              {(PW+4){1'b0}});
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    mon_en  = 1'b1;
    idle(12);
    step(1'b1, 1'b0, 1'b0);
    idle(6);

    mon_en = 1'b0;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dual_edge_regen.md
# dual_edge_regen

Level regenerator: rebuilds a level waveform from one-cycle `rise`/`fall` edge strobes, the inverse of the dual-edge detector. Every accepted strobe toggles `out`. Each new level is held for at least `MIN_HOLD` cycles, and strobes arriving during a hold are queued. Sits downstream of edge-compressed signalling paths, on the same clock domain as the strobe source.

## Interface
- `MIN_HOLD`, 4: minimum cycles `out` stays stable after any toggle; legal range ≥1.
- `PEND_DEPTH`, 3: maximum queued strobes; legal range ≥1.
- `PW` (localparam): `$clog2(PEND_DEPTH+1)`.
- Clocking (already decided): one clock `clk`; reset `reset_n` is asynchronous, active-low.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `rise`  in  1  one-cycle strobe: `out` must go high.
- `fall`  in  1  one-cycle strobe: `out` must go low.
- `clr`  in  1  synchronous clear of `ovf` and `err`.
- `out`  out  1  regenerated level, registered.
- `busy`  out  1  high while in HOLD.
- `pending`  out  PW  queued toggle count.
- `ovf`  out  1  sticky: a strobe was dropped because the queue was full.
- `err`  out  1  sticky: direction error (see Configuration).

## Operation
- **Strobe qualification**
  - `rise` and `fall` high in the same cycle: the strobe is dropped (net zero change), and sets `err` when the checker is compiled in.
  - Otherwise, exactly one high = one strobe `s`.
- **IDLE state** (hold expired, `pending`=0):
  - `s` → toggle `out`, load `hold_cnt`=`MIN_HOLD`-1, go to HOLD.
- **HOLD state**, `hold_cnt`≠0:
  - decrement `hold_cnt`.
  - `s` → `pending`+1.
  - If `pending`==`PEND_DEPTH`: drop `s` and set `ovf`.
- **HOLD state**, `hold_cnt`==0 (expiry cycle):
  - Compute `p` = `pending` + `s`. The same-cycle strobe counts, and is not subject to overflow when `pending`==`PEND_DEPTH` (dequeue and enqueue net).
  - `p`>0 → toggle `out`, `pending`←`p`-1, reload `hold_cnt`=`MIN_HOLD`-1, stay in HOLD.
  - `p`==0 → go to IDLE.
- **Outputs**
  - `busy` = (state==HOLD).
  - `pending` saturates at `PEND_DEPTH` and never wraps.
- **`clr`**
  - clears `ovf`/`err` next edge.
  - A new error event in the same cycle as `clr` wins: the flag stays 1.
- **Reset mid-operation:** queue and hold are discarded immediately and asynchronously; `out` is forced to 0.

## Timing
- Reset values: `out`=0, `busy`=0, `pending`=0, `ovf`=0, `err`=0, state IDLE, `hold_cnt`=0.
- Latency: a strobe sampled at edge N while IDLE changes `out` after edge N (visible in cycle N+1).
- Spacing: consecutive toggles of `out` are exactly `MIN_HOLD` cycles apart while the queue is non-empty, and never fewer.
- With `MIN_HOLD`=1, back-to-back strobes toggle `out` every cycle and `pending` stays 0.
- Reset deassertion: `reset_n` is synchronised externally; the first strobe is accepted on the first edge after deassertion.

## Configuration
- Macro: `DUAL_REGEN_DIR_CHECK_EN`.
- **Defined:**
  - Expected direction = `out` XOR parity(`pending`).
  - A `rise` when the expected level is already 1, or a `fall` when it is already 0, is dropped and sets `err`.
  - Simultaneous `rise`+`fall` also sets `err`.
- **Undefined:**
  - `rise` and `fall` are both plain toggle requests.
  - Simultaneous `rise`+`fall` is still dropped.
  - `err` is tied to 0.

## Test plan
- **Basic toggle:** `MIN_HOLD`=4. Reset, then `rise` at cycle 10 → `out`=1 from cycle 11, `busy`=1 for cycles 11–14, IDLE at 15.
- **Queueing:** `rise` at 10, `fall` at 11, `rise` at 12 → `out` transitions at 11, 15 and 19. `pending` peaks at 2, and `busy` drops at 23.
- **Overflow:** `PEND_DEPTH`=3. One toggling strobe, then 4 alternating strobes during the hold → `pending`=3, `ovf`=1. Exactly 3 further toggles occur. `clr` → `ovf`=0 next cycle.
- **Expiry collision:** a strobe exactly on the expiry cycle with `pending`=0 → `out` toggles on that edge and `busy` stays 1.
- **Direction error (macro defined):** `rise` while `out`=1 and idle → `out` unchanged, `err`=1. Repeat with the macro undefined → `out` toggles to 0, `err`=0.
- **Async reset mid-hold:** assert `reset_n`=0 mid-hold with `pending`=2 → `out`, `pending` and `busy` go to 0 immediately without waiting for a clock. After release, no queued toggles replay.
